// File: rtl/sprite_pkg.sv
// Shared types and default sizing for the sprite compositor: object table entry,
// colour mode and the per-pixel attributes carried alongside the image ROM read.
package sprite_pkg;

    localparam int unsigned N_OBJ_DEF   = 64;
    localparam int unsigned H_W_DEF     = 10;
    localparam int unsigned V_W_DEF     = 10;
    localparam int unsigned SIZE_W_DEF  = 8;
    localparam int unsigned COLOR_W_DEF = 12;
    localparam int unsigned ROM_AW_DEF  = 14;
    localparam int unsigned ROM_LAT_DEF = 1;
    localparam int unsigned IMG_W       = 3;

    typedef enum logic {
        MODE_MASK   = 1'b0,
        MODE_DIRECT = 1'b1
    } obj_mode_e;

    typedef struct packed {
        logic                   en;
        obj_mode_e              mode;
        logic [IMG_W-1:0]       img_id;
        logic [V_W_DEF-1:0]     vpos;
        logic [H_W_DEF-1:0]     hpos;
        logic [SIZE_W_DEF-1:0]  size;
        logic [COLOR_W_DEF-1:0] color;
    } obj_t;

    typedef struct packed {
        logic                   valid;
        logic                   hit;
        obj_mode_e              mode;
        logic [COLOR_W_DEF-1:0] color;
    } carry_t;

endpackage

// File: rtl/prio_enc2.sv
// Two-deep priority encoder: index of the lowest and second-lowest set bits.
module prio_enc2 #(
    parameter  int unsigned WIDTH = 64,
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] first,
    output logic [IDX_W-1:0] second,
    output logic             found_first,
    output logic             found_second
);

    always_comb begin
        first        = '0;
        second       = '0;
        found_first  = 1'b0;
        found_second = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                if (!found_first) begin
                    first       = IDX_W'(i);
                    found_first = 1'b1;
                end else if (!found_second) begin
                    second       = IDX_W'(i);
                    found_second = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sprite_engine.sv
// Per-pixel object compositor: double-buffered object table, priority hit resolve,
// image ROM fetch and final pixel colouring, plus a collision report handshake.
module sprite_engine
    import sprite_pkg::*;
#(
    parameter  int unsigned N_OBJ   = N_OBJ_DEF,
    parameter  int unsigned H_W     = H_W_DEF,
    parameter  int unsigned V_W     = V_W_DEF,
    parameter  int unsigned SIZE_W  = SIZE_W_DEF,
    parameter  int unsigned COLOR_W = COLOR_W_DEF,
    parameter  int unsigned ROM_AW  = ROM_AW_DEF,
    parameter  int unsigned ROM_LAT = ROM_LAT_DEF,
    localparam int unsigned IDX_W   = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
    input  logic               clk25M,
    input  logic               reset,
    input  logic [H_W-1:0]     whpos,
    input  logic [V_W-1:0]     wvpos,
    input  logic               pix_valid,
    input  logic               frame_start,
    input  logic               tbl_we,
    input  logic [IDX_W-1:0]   tbl_addr,
    input  obj_t               tbl_wdata,
    output logic [ROM_AW-1:0]  rom_addr,
    output logic [IMG_W-1:0]   rom_sel,
    input  logic [COLOR_W-1:0] rom_data,
    output logic [COLOR_W-1:0] pix_out,
    output logic               pix_out_valid,
    output logic               coll_valid,
    output logic [IDX_W-1:0]   coll_a,
    output logic [IDX_W-1:0]   coll_b,
    output logic               coll_ovf,
    input  logic               coll_ack
);

    localparam int unsigned PROD_W = V_W + SIZE_W;

    obj_t shadow_q [N_OBJ];
    obj_t active_q [N_OBJ];

    logic [N_OBJ-1:0] hit_vec;
    logic [IDX_W-1:0] win_idx, sec_idx;
    logic             found1, found2;
    logic [H_W-1:0]   win_dx;
    logic [V_W-1:0]   win_dy;
    logic             new_coll;

    logic               s0_valid_q, s0_hit_q;
    logic [H_W-1:0]     s0_dx_q;
    logic [V_W-1:0]     s0_dy_q;
    logic [SIZE_W-1:0]  s0_size_q;
    logic [IMG_W-1:0]   s0_img_q;
    obj_mode_e          s0_mode_q;
    logic [COLOR_W-1:0] s0_color_q;
    logic [PROD_W-1:0]  texel_off;

    carry_t             s1_q;
    carry_t             pipe_q [ROM_LAT];
    carry_t             last;
    logic [COLOR_W-1:0] pix_d;

    // Commit copies the pre-write shadow, so a same-cycle write waits for the next frame.
    always_ff @(posedge clk25M or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_OBJ; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            if (frame_start) begin
                for (int i = 0; i < N_OBJ; i++) begin
                    active_q[i] <= shadow_q[i];
                end
            end
            if (tbl_we) begin
                shadow_q[tbl_addr] <= tbl_wdata;
            end
        end
    end

    // Bounds are widened by one bit so objects near the right/bottom edge never wrap.
    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < N_OBJ; i++) begin
            hit_vec[i] = active_q[i].en
                && ((H_W+1)'(active_q[i].hpos) <= {1'b0, whpos})
                && ({1'b0, whpos} < (H_W+1)'(active_q[i].hpos) + (H_W+1)'(active_q[i].size))
                && ((V_W+1)'(active_q[i].vpos) <= {1'b0, wvpos})
                && ({1'b0, wvpos} < (V_W+1)'(active_q[i].vpos) + (V_W+1)'(active_q[i].size));
        end
    end

    prio_enc2 #(
        .WIDTH (N_OBJ)
    ) u_prio (
        .vec          (hit_vec),
        .first        (win_idx),
        .second       (sec_idx),
        .found_first  (found1),
        .found_second (found2)
    );

    assign win_dx   = whpos - H_W'(active_q[win_idx].hpos);
    assign win_dy   = wvpos - V_W'(active_q[win_idx].vpos);
    assign new_coll = pix_valid && found2;

    always_ff @(posedge clk25M or posedge reset) begin
        if (reset) begin
            s0_valid_q <= 1'b0;
            s0_hit_q   <= 1'b0;
            s0_dx_q    <= '0;
            s0_dy_q    <= '0;
            s0_size_q  <= '0;
            s0_img_q   <= '0;
            s0_mode_q  <= MODE_MASK;
            s0_color_q <= '0;
        end else begin
            s0_valid_q <= pix_valid;
            s0_hit_q   <= pix_valid && found1;
            s0_dx_q    <= win_dx;
            s0_dy_q    <= win_dy;
            s0_size_q  <= SIZE_W'(active_q[win_idx].size);
            s0_img_q   <= active_q[win_idx].img_id;
            s0_mode_q  <= active_q[win_idx].mode;
            s0_color_q <= COLOR_W'(active_q[win_idx].color);
        end
    end

    assign texel_off = PROD_W'(s0_dy_q) * PROD_W'(s0_size_q) + PROD_W'(s0_dx_q);

    always_ff @(posedge clk25M or posedge reset) begin
        if (reset) begin
            rom_addr <= '0;
            rom_sel  <= '0;
            s1_q     <= '0;
        end else begin
            rom_addr    <= s0_hit_q ? ROM_AW'(texel_off) : '0;
            rom_sel     <= s0_hit_q ? s0_img_q : '0;
            s1_q.valid  <= s0_valid_q;
            s1_q.hit    <= s0_hit_q;
            s1_q.mode   <= s0_mode_q;
            s1_q.color  <= COLOR_W_DEF'(s0_color_q);
        end
    end

    // Attributes ride alongside the ROM so they line up with rom_data.
    always_ff @(posedge clk25M or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= s1_q;
            for (int i = 1; i < ROM_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign last = pipe_q[ROM_LAT-1];

    always_comb begin
        pix_d = '0;
        if (last.valid && last.hit) begin
            if (last.mode == MODE_DIRECT) begin
                pix_d = rom_data;
            end else if (rom_data[0]) begin
                pix_d = COLOR_W'(last.color);
            end
        end
    end

    always_ff @(posedge clk25M or posedge reset) begin
        if (reset) begin
            pix_out       <= '0;
            pix_out_valid <= 1'b0;
        end else begin
            pix_out       <= pix_d;
            pix_out_valid <= last.valid;
        end
    end

    // An ack in the same cycle as a new collision frees the slot for the new report.
    always_ff @(posedge clk25M or posedge reset) begin
        if (reset) begin
            coll_valid <= 1'b0;
            coll_a     <= '0;
            coll_b     <= '0;
            coll_ovf   <= 1'b0;
        end else if (new_coll && (!coll_valid || coll_ack)) begin
            coll_valid <= 1'b1;
            coll_a     <= win_idx;
            coll_b     <= sec_idx;
            coll_ovf   <= 1'b0;
        end else if (coll_ack) begin
            coll_valid <= 1'b0;
            coll_ovf   <= 1'b0;
        end else if (new_coll) begin
            coll_ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sprite_engine.sv
// Bench for sprite_engine: directed scenarios with literal expectations, then random
// traffic compared every cycle against an arithmetic model of the object table.
module tb_sprite_engine;
    import sprite_pkg::*;

    localparam int N  = 64;
    localparam int HN = 256;

    logic        clk25M      = 1'b0;
    logic        reset       = 1'b0;
    logic [9:0]  whpos       = '0;
    logic [9:0]  wvpos       = '0;
    logic        pix_valid   = 1'b0;
    logic        frame_start = 1'b0;
    logic        tbl_we      = 1'b0;
    logic [5:0]  tbl_addr    = '0;
    obj_t        tbl_wdata   = '0;
    logic [13:0] rom_addr;
    logic [2:0]  rom_sel;
    logic [11:0] rom_data    = '0;
    logic [11:0] pix_out;
    logic        pix_out_valid;
    logic        coll_valid;
    logic [5:0]  coll_a, coll_b;
    logic        coll_ovf;
    logic        coll_ack    = 1'b0;

    sprite_engine u_dut (
        .clk25M        (clk25M),
        .reset         (reset),
        .whpos         (whpos),
        .wvpos         (wvpos),
        .pix_valid     (pix_valid),
        .frame_start   (frame_start),
        .tbl_we        (tbl_we),
        .tbl_addr      (tbl_addr),
        .tbl_wdata     (tbl_wdata),
        .rom_addr      (rom_addr),
        .rom_sel       (rom_sel),
        .rom_data      (rom_data),
        .pix_out       (pix_out),
        .pix_out_valid (pix_out_valid),
        .coll_valid    (coll_valid),
        .coll_a        (coll_a),
        .coll_b        (coll_b),
        .coll_ovf      (coll_ovf),
        .coll_ack      (coll_ack)
    );

    always #20 clk25M = ~clk25M;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rom_fn(int sel, int addr);
        return (addr * 7 + sel * 300 + 5) % 4096;
    endfunction

    // Image ROM with one cycle of read latency.
    always @(posedge clk25M) rom_data <= 12'(rom_fn(int'(rom_sel), int'(rom_addr)));

    typedef struct {
        int en, mode, img, h, v, s, col;
    } mobj_t;

    typedef struct {
        bit valid, hit;
        int addr, sel, pix;
    } exp_t;

    mobj_t shadow_m [N];
    mobj_t active_m [N];
    exp_t  hist [HN];
    int    edge_n = 0;
    bit    mc_valid = 0, mc_ovf = 0;
    int    mc_a = 0, mc_b = 0;

    function automatic bit covers(mobj_t o, int x, int y);
        return o.en != 0 && o.h <= x && x < o.h + o.s && o.v <= y && y < o.v + o.s;
    endfunction

    always @(posedge clk25M) begin : model
        exp_t  e;
        mobj_t w;
        int    first, second, x, y, rom;
        bit    pair;
        edge_n++;
        e.valid = 0; e.hit = 0; e.addr = 0; e.sel = 0; e.pix = 0;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                shadow_m[i] = '{default: 0};
                active_m[i] = '{default: 0};
            end
            mc_valid = 0; mc_ovf = 0; mc_a = 0; mc_b = 0;
        end else begin
            first = -1; second = -1;
            x = int'(whpos); y = int'(wvpos);
            if (pix_valid) begin
                for (int i = 0; i < N; i++) begin
                    if (covers(active_m[i], x, y)) begin
                        if (first < 0) first = i;
                        else if (second < 0) second = i;
                    end
                end
                e.valid = 1;
                if (first >= 0) begin
                    w      = active_m[first];
                    e.hit  = 1;
                    e.sel  = w.img;
                    e.addr = ((y - w.v) * w.s + (x - w.h)) % 16384;
                    rom    = rom_fn(e.sel, e.addr);
                    e.pix  = (w.mode != 0) ? rom : ((rom % 2 == 1) ? w.col : 0);
                end
            end
            pair = pix_valid && second >= 0;
            if (pair && (!mc_valid || coll_ack)) begin
                mc_valid = 1; mc_a = first; mc_b = second; mc_ovf = 0;
            end else if (coll_ack) begin
                mc_valid = 0; mc_ovf = 0;
            end else if (pair) begin
                mc_ovf = 1;
            end
            if (frame_start) active_m = shadow_m;
            if (tbl_we) begin
                shadow_m[int'(tbl_addr)].en   = int'(tbl_wdata.en);
                shadow_m[int'(tbl_addr)].mode = int'(tbl_wdata.mode);
                shadow_m[int'(tbl_addr)].img  = int'(tbl_wdata.img_id);
                shadow_m[int'(tbl_addr)].h    = int'(tbl_wdata.hpos);
                shadow_m[int'(tbl_addr)].v    = int'(tbl_wdata.vpos);
                shadow_m[int'(tbl_addr)].s    = int'(tbl_wdata.size);
                shadow_m[int'(tbl_addr)].col  = int'(tbl_wdata.color);
            end
        end
        hist[edge_n % HN] = e;
    end

    always @(negedge clk25M) begin : compare
        exp_t e3, e1;
        if (reset) begin
            chk("rst_pix_out", int'(pix_out), 0);
            chk("rst_pix_out_valid", int'(pix_out_valid), 0);
            chk("rst_rom_addr", int'(rom_addr), 0);
            chk("rst_coll_valid", int'(coll_valid), 0);
            chk("rst_coll_ovf", int'(coll_ovf), 0);
        end else begin
            e3 = hist[(edge_n + HN - 3) % HN];
            e1 = hist[(edge_n + HN - 1) % HN];
            chk("pix_out_valid", int'(pix_out_valid), int'(e3.valid));
            if (e3.valid) chk("pix_out", int'(pix_out), e3.pix);
            if (e1.valid && e1.hit) begin
                chk("rom_addr", int'(rom_addr), e1.addr);
                chk("rom_sel", int'(rom_sel), e1.sel);
            end
            chk("coll_valid", int'(coll_valid), int'(mc_valid));
            chk("coll_ovf", int'(coll_ovf), int'(mc_ovf));
            if (mc_valid) begin
                chk("coll_a", int'(coll_a), mc_a);
                chk("coll_b", int'(coll_b), mc_b);
            end
        end
    end

    task automatic tick();
        @(posedge clk25M);
        #1;
    endtask

    task automatic set_obj(int slot, bit en, bit mode, int img, int h, int v, int s, int col);
        tbl_addr         = 6'(slot);
        tbl_wdata.en     = en;
        tbl_wdata.mode   = mode ? MODE_DIRECT : MODE_MASK;
        tbl_wdata.img_id = 3'(img);
        tbl_wdata.hpos   = 10'(h);
        tbl_wdata.vpos   = 10'(v);
        tbl_wdata.size   = 8'(s);
        tbl_wdata.color  = 12'(col);
    endtask

    task automatic wr(int slot, bit en, bit mode, int img, int h, int v, int s, int col);
        set_obj(slot, en, mode, img, h, v, s, col);
        tbl_we = 1'b1;
        tick();
        tbl_we = 1'b0;
    endtask

    task automatic commit();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic pix(int x, int y);
        pix_valid = 1'b1;
        whpos     = 10'(x);
        wvpos     = 10'(y);
        tick();
        pix_valid = 1'b0;
    endtask

    initial begin
        #5 reset = 1'b1;
        repeat (4) tick();
        reset = 1'b0;
        tick();

        // Direct-mode object: texel addresses at both corners.
        wr(3, 1, 1, 2, 100, 50, 32, 0);
        commit();
        pix_valid = 1'b1; whpos = 10'd100; wvpos = 10'd50;
        tick();
        whpos = 10'd131; wvpos = 10'd81;
        tick();
        pix_valid = 1'b0;
        chk("addr_origin", int'(rom_addr), 0);
        chk("sel_origin", int'(rom_sel), 2);
        tick();
        chk("addr_corner", int'(rom_addr), 1023);
        tick();
        chk("pix_origin", int'(pix_out), 605);
        chk("pix_origin_valid", int'(pix_out_valid), 1);
        tick();
        chk("pix_corner", int'(pix_out), 3670);

        // Overlap: slot 2 wins, collision reported next cycle.
        wr(2, 1, 1, 1, 190, 190, 20, 0);
        wr(5, 1, 0, 4, 195, 195, 16, 12'hF00);
        commit();
        pix(200, 200);
        chk("coll_first_valid", int'(coll_valid), 1);
        chk("coll_first_a", int'(coll_a), 2);
        chk("coll_first_b", int'(coll_b), 5);
        chk("coll_first_ovf", int'(coll_ovf), 0);
        repeat (3) tick();
        chk("pix_winner", int'(pix_out), 1775);

        // Second overlap while pending, then ack coincident with a new one.
        pix(201, 201);
        chk("ovf_set", int'(coll_ovf), 1);
        chk("ovf_a_kept", int'(coll_a), 2);
        chk("ovf_b_kept", int'(coll_b), 5);
        wr(1, 1, 1, 0, 400, 300, 10, 0);
        wr(7, 1, 1, 0, 405, 305, 10, 0);
        commit();
        coll_ack = 1'b1;
        pix(406, 306);
        coll_ack = 1'b0;
        chk("ack_new_a", int'(coll_a), 1);
        chk("ack_new_b", int'(coll_b), 7);
        chk("ack_new_ovf", int'(coll_ovf), 0);
        chk("ack_new_valid", int'(coll_valid), 1);
        coll_ack = 1'b1;
        tick();
        coll_ack = 1'b0;
        chk("ack_clear", int'(coll_valid), 0);

        // Write in the commit cycle only shows after the following commit.
        set_obj(0, 1, 1, 5, 0, 0, 8, 0);
        tbl_we = 1'b1; frame_start = 1'b1;
        tick();
        tbl_we = 1'b0; frame_start = 1'b0;
        pix(3, 3);
        repeat (3) tick();
        chk("late_write_hidden", int'(pix_out), 0);
        chk("late_write_valid", int'(pix_out_valid), 1);
        commit();
        pix(3, 3);
        repeat (3) tick();
        chk("late_write_shown", int'(pix_out), 1694);

        // Mask mode with tint colour.
        pix(210, 210);
        repeat (3) tick();
        chk("mask_clear", int'(pix_out), 0);
        pix(209, 210);
        repeat (3) tick();
        chk("mask_set", int'(pix_out), 12'hF00);

        // Object straddling the right edge must not wrap to column 0.
        wr(9, 1, 1, 6, 1000, 500, 32, 0);
        commit();
        pix(5, 505);
        repeat (3) tick();
        chk("no_wrap", int'(pix_out), 0);
        pix(1023, 510);
        repeat (3) tick();
        chk("edge_hit", int'(pix_out), 110);

        // Asynchronous reset with a collision pending and a pixel in flight.
        pix(200, 200);
        pix_valid = 1'b1; whpos = 10'd1023; wvpos = 10'd510;
        tick();
        pix_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("async_pix_valid", int'(pix_out_valid), 0);
        chk("async_coll_valid", int'(coll_valid), 0);
        chk("async_rom_sel", int'(rom_sel), 0);
        repeat (4) tick();
        reset = 1'b0;
        pix(200, 200);
        repeat (3) tick();
        chk("post_reset_pix", int'(pix_out), 0);
        chk("post_reset_coll", int'(coll_valid), 0);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            pix_valid = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) whpos = 10'($urandom_range(960, 1023));
            else whpos = 10'($urandom_range(0, 320));
            wvpos       = 10'($urandom_range(0, 320));
            coll_ack    = ($urandom_range(0, 4) == 0);
            frame_start = ($urandom_range(0, 39) == 0);
            tbl_we      = ($urandom_range(0, 5) == 0);
            set_obj(($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63))
                                                  : int'($urandom_range(0, 11)),
                    ($urandom_range(0, 4) != 0), $urandom_range(0, 1) == 1,
                    int'($urandom_range(0, 7)),
                    ($urandom_range(0, 7) == 0) ? int'($urandom_range(980, 1023))
                                                : int'($urandom_range(0, 300)),
                    int'($urandom_range(0, 300)),
                    ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 64)),
                    int'($urandom_range(0, 4095)));
            tick();
        end
        pix_valid = 1'b0; tbl_we = 1'b0; frame_start = 1'b0; coll_ack = 1'b0;
        repeat (8) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_engine.md
# sprite_engine

Parametrised per-pixel object compositor for the VGA game path: holds a double-buffered table of N_OBJ screen objects, resolves for each raster pixel the highest-priority enabled object covering it, fetches its image texel from an external image ROM and emits the final 12-bit pixel. It generalises the fixed 63-invader/40-laser renderer with a configurable object count, frame-synchronous table commit, tinted or direct-colour modes, and a collision-report handshake. It sits between the raster counter and the VRAM write stage.

## Interface
- N_OBJ, 64: number of object slots; lower index = higher priority
- H_W, 10: horizontal coordinate width
- V_W, 10: vertical coordinate width
- SIZE_W, 8: object edge length width (objects are square)
- COLOR_W, 12: pixel/colour width
- ROM_AW, 14: image ROM address width
- ROM_LAT, 1: image ROM read latency in cycles (≥1)
- clk25M  in  1  pixel clock; one clock for the whole block
- reset  in  1  asynchronous, active-high
- whpos  in  H_W  horizontal position of current pixel
- wvpos  in  V_W  vertical position of current pixel
- pix_valid  in  1  whpos/wvpos valid this cycle
- frame_start  in  1  one-cycle pulse at vblank start; commits shadow table
- tbl_we  in  1  shadow-table write strobe
- tbl_addr  in  $clog2(N_OBJ)  slot index
- tbl_wdata  in  obj_t  entry {en, mode, img_id[2:0], vpos, hpos, size, color}
- rom_addr  out  ROM_AW  texel address
- rom_sel  out  3  image select (img_id of winning object)
- rom_data  in  COLOR_W  texel, valid ROM_LAT cycles after rom_addr
- pix_out  out  COLOR_W  composited pixel
- pix_out_valid  out  1  pix_out valid
- coll_valid  out  1  collision report pending
- coll_a, coll_b  out  $clog2(N_OBJ)  colliding slots, coll_a < coll_b
- coll_ovf  out  1  further collision dropped while pending
- coll_ack  in  1  consumer acknowledge

## Operation
- Two tables: shadow (written by tbl_we) and active (used for rendering). On frame_start, active <= shadow (pre-write contents); a tbl_we in the same cycle updates shadow only, visible at the next commit.
- Hit test per slot: en & hpos ≤ whpos < hpos+size & vpos ≤ wvpos < vpos+size; sums computed at H_W+1/V_W+1 bits, no wrap; off-screen parts simply never hit.
- Priority: winner = lowest hitting index; second = next lowest hitting index.
- Texel address: (wvpos−vpos)*size + (whpos−hpos), truncated to ROM_AW.
- Output: no hit → 0; mode 0 (mask) → rom_data[0] ? color : 0; mode 1 (direct) → rom_data.
- Collision: a valid pixel with ≥2 hits while coll_valid=0 latches coll_a/coll_b, sets coll_valid. While pending, further collisions set coll_ovf. coll_ack clears coll_valid and coll_ovf; ack and new collision in same cycle → new one latched, coll_ovf=0.
- Reset (any time, async): both tables all-zero (all disabled), pipeline flushed, all outputs 0.

## Timing
- Stage 0 (register): hit vector, winner/second encode, offsets.
- Stage 1: rom_addr, rom_sel registered; winner fields carried.
- Stages 2..1+ROM_LAT: carry mode/color/hit alongside ROM.
- pix_out/pix_out_valid registered: latency = 2+ROM_LAT cycles from pix_valid (3 at default); one pixel per cycle, no stalls.
- coll_valid rises 1 cycle after the triggering pix_valid cycle.
- frame_start effect: pixels sampled in the cycle after the pulse use new table.

## Structure
- sprite_pkg: obj_t packed struct, obj_mode_e {MODE_MASK, MODE_DIRECT}, default parameter constants.
- One sub-module: prio_enc2 (parametrised width; returns first and second set index plus found flags), used once.

## Test plan
- Slot 3 {en, mode 1, hpos 100, vpos 50, size 32} committed; pixel (100,50) → rom_addr 0, (131,81) → 1023; pix_out = rom_data 3 cycles later.
- Slots 2 and 5 overlapping at (200,200) → winner 2 drives pix_out; coll_valid, coll_a=2, coll_b=5 next cycle.
- Second overlap before ack → coll_ovf=1, coll_a/b unchanged; coll_ack coincident with new overlap (1,7) → coll_a=1, coll_b=7, coll_ovf=0.
- tbl_we to slot 0 in the frame_start cycle → no effect this frame, takes effect after next frame_start.
- Mode 0, color 12'hF00, rom_data 1 → 12'hF00; rom_data 0 → 0; hpos 630, size 32 → no hit beyond whpos 639, no wrap.
- Reset asserted mid-frame → all outputs 0 asynchronously; after release all pixels 0 until a commit.
